// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one sync-read instruction memory port between fetch and loader
module imem_arbiter #(
  parameter int N = 32,
  parameter int AW = 9,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [N-1:0]  f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [AW-1:0] l_addr,
  input  logic [N-1:0]  l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [N-1:0]  l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata
);
  logic [3:0] starve_cnt;
  logic lock_own, rd_pend, rd_owner, l_win;
  // grant selection, memory port mux and read-data steering
  always_comb begin
    l_win = l_req & (!f_req | lock_own | (starve_cnt == 4'(STARVE)));
    l_gnt = !rst & l_win;
    f_gnt = !rst & f_req & !l_win;
    mem_en = f_gnt | l_gnt;
    mem_we = l_gnt & l_we;
    mem_addr = l_gnt ? l_addr : f_gnt ? f_addr : '0;
    mem_wdata = l_gnt ? l_wdata : '0;
    f_rvalid = !rst & rd_pend & !rd_owner;
    l_rvalid = !rst & rd_pend & rd_owner;
    f_rdata = f_rvalid ? mem_rdata : '0;
    l_rdata = l_rvalid ? mem_rdata : '0;
  end
  // starvation counter, loader lock and pending-read tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      lock_own <= 1'b0;
      rd_pend <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      starve_cnt <= (l_gnt | !l_req) ? 4'd0 :
                    (f_gnt & !lock_own & (starve_cnt < 4'(STARVE))) ? starve_cnt + 4'd1 : starve_cnt;
      lock_own <= (!l_lock | !l_req) ? 1'b0 : l_gnt ? 1'b1 : lock_own;
      rd_pend <= f_gnt | (l_gnt & !l_we);
      rd_owner <= l_gnt;
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: table-driven directed checks of the instruction memory arbiter
module tb_imem_arbiter;
  logic clk = 0, rst;
  logic f_req, l_req, l_we, l_lock;
  logic [8:0] f_addr, l_addr, mem_addr;
  logic [31:0] l_wdata, f_rdata, l_rdata, mem_wdata, mem_rdata;
  logic f_gnt, f_rvalid, l_gnt, l_rvalid, mem_en, mem_we;
  logic [31:0] mem [512];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.N(32), .AW(9), .STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mv(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  initial for (int i = 0; i < 512; i++) mem[i] = mv(i);

  always @(posedge clk) if (mem_en) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_we) ? mem_wdata : mem[mem_addr];
  end

  typedef struct {
    logic rst, fr, lr, lw, lk;
    logic [8:0] fa, la;
    logic [31:0] ld;
    logic fg, lg, we, fv, lv;
    logic [8:0] ma;
    logic [31:0] md, rd;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(input logic r, fr, input int fa, input logic lr, lw, lk, input int la,
                              input logic [31:0] ld, input logic fg, lg, fv, lv, input logic [31:0] rd);
    vec_t t;
    t.rst = r; t.fr = fr; t.fa = 9'(fa); t.lr = lr; t.lw = lw; t.lk = lk; t.la = 9'(la); t.ld = ld;
    t.fg = fg; t.lg = lg; t.fv = fv; t.lv = lv; t.rd = rd;
    t.we = lg & lw;
    t.ma = lg ? 9'(la) : fg ? 9'(fa) : 9'd0;
    t.md = lg ? ld : 32'd0;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    rst = t.rst; f_req = t.fr; f_addr = t.fa; l_req = t.lr; l_we = t.lw; l_lock = t.lk;
    l_addr = t.la; l_wdata = t.ld;
  endtask

  initial begin
    vec_t z;
    z = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0);
    apply(z);
    v.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0));
    v.push_back(mk(1,1,3,0,0,0,0,0, 0,0,0,0,0));
    v.push_back(z);
    v.push_back(z);
    for (int i = 0; i < 8; i++) v.push_back(mk(0,1,i,0,0,0,0,0, 1,0,i>0,0, i>0 ? mv(i-1) : 0));
    v.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,mv(7)));
    v.push_back(z);
    for (int i = 0; i < 4; i++) v.push_back(mk(0,1,'h40,1,0,0,'h10,0, 1,0,i>0,0, i>0 ? mv('h40) : 0));
    v.push_back(mk(0,1,'h40,1,0,0,'h10,0, 0,1,1,0,mv('h40)));
    v.push_back(mk(0,1,'h41,0,0,0,0,0, 1,0,0,1,mv('h10)));
    v.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,mv('h41)));
    v.push_back(mk(0,0,0,1,1,0,5,32'hDEADBEEF, 0,1,0,0,0));
    v.push_back(mk(0,0,0,1,0,0,5,0, 0,1,0,0,0));
    v.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,32'hDEADBEEF));
    for (int i = 0; i < 4; i++) v.push_back(mk(0,1,'h50,1,1,1,'h20,'hA0, 1,0,i>0,0, i>0 ? mv('h50) : 0));
    for (int i = 0; i < 4; i++) v.push_back(mk(0,1,'h50,1,1,1,'h20+i,'hA0+i, 0,1,i==0,0, i==0 ? mv('h50) : 0));
    v.push_back(mk(0,1,'h50,0,0,0,0,0, 1,0,0,0,0));
    v.push_back(mk(0,1,'h51,1,0,0,'h20,0, 1,0,1,0,mv('h50)));
    for (int i = 0; i < 4; i++)
      v.push_back(mk(0,0,0,1,0,0,'h20+i,0, 0,1,i==0,i>0, i==0 ? mv('h51) : 32'(32'hA0+i-1)));
    v.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,32'hA3));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      chk("f_gnt", k, 32'(f_gnt), 32'(v[k].fg));
      chk("l_gnt", k, 32'(l_gnt), 32'(v[k].lg));
      chk("gnt_excl", k, 32'(f_gnt & l_gnt), 0);
      chk("mem_en", k, 32'(mem_en), 32'(v[k].fg | v[k].lg));
      chk("mem_we", k, 32'(mem_we), 32'(v[k].we));
      chk("mem_addr", k, 32'(mem_addr), 32'(v[k].ma));
      chk("mem_wdata", k, mem_wdata, v[k].md);
      chk("f_rvalid", k, 32'(f_rvalid), 32'(v[k].fv));
      chk("l_rvalid", k, 32'(l_rvalid), 32'(v[k].lv));
      chk("f_rdata", k, f_rdata, v[k].fv ? v[k].rd : 32'd0);
      chk("l_rdata", k, l_rdata, v[k].lv ? v[k].rd : 32'd0);
      @(posedge clk);
      #1;
    end
    // reset arriving while a fetch read is outstanding drops it
    apply(mk(0,1,3,0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    chk("rst_seq_fgnt", 0, 32'(f_gnt), 1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rst_seq_fgnt", 1, 32'(f_gnt), 0);
    chk("rst_seq_mem_en", 1, 32'(mem_en), 0);
    chk("rst_seq_fvalid", 1, 32'(f_rvalid), 0);
    chk("rst_seq_fdata", 1, f_rdata, 0);
    @(posedge clk); #1;
    apply(z);
    @(negedge clk);
    chk("rst_seq_fvalid", 2, 32'(f_rvalid), 0);
    chk("rst_seq_lvalid", 2, 32'(l_rvalid), 0);
    // starvation counter restarts after reset: F wins 4 times, then L
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      apply(mk(0,1,'h60,1,0,0,'h11,0, 0,0,0,0,0));
      @(negedge clk);
      chk("post_rst_fgnt", i, 32'(f_gnt), 32'(i < 4));
      chk("post_rst_lgnt", i, 32'(l_gnt), 32'(i == 4));
    end
    @(posedge clk); #1;
    apply(z);
    @(negedge clk);
    chk("post_rst_lvalid", 0, 32'(l_rvalid), 1);
    chk("post_rst_ldata", 0, l_rdata, mv('h11));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction-memory port between two requesters:
  - the fetch stage (requester F, read-only);
  - the program loader/debug port (requester L, read or write).
- Grants one access per cycle and routes the synchronous-read data (1-cycle latency) back to the owner.
- Fetch normally has priority. A starvation counter and a loader lock guarantee loader progress, so boot-time program load and debug reads can run alongside the running core.

Parameters:
- N, 32, data width of a memory word.
- AW, 9, word address width of the instruction memory.
- STARVE, 4, max consecutive fetch grants while L waits before L is forced a grant (1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- f_req  input  1  fetch access request.
- f_addr  input  AW  fetch word address.
- f_gnt  output  1  fetch granted this cycle (combinational).
- f_rvalid  output  1  fetch read data valid.
- f_rdata  output  N  fetch read data.
- l_req  input  1  loader access request.
- l_we  input  1  loader write (1) / read (0).
- l_lock  input  1  loader requests back-to-back ownership (burst).
- l_addr  input  AW  loader word address.
- l_wdata  input  N  loader write data.
- l_gnt  output  1  loader granted this cycle (combinational).
- l_rvalid  output  1  loader read data valid.
- l_rdata  output  N  loader read data.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  N  memory write data.
- mem_rdata  input  N  memory read data, valid the cycle after an enabled read.

Behaviour:
- Interface:
  - One clock.
  - Reset is synchronous and active-high.
  - Ports are named clk and rst.
- Requesters:
  - Hold req, addr, we and wdata stable until gnt.
  - A new request may be presented the cycle after gnt.
- Grant selection (combinational; state registered):
  - rst=1: f_gnt=l_gnt=mem_en=0.
  - Only one req high: that requester is granted.
  - Both high: L wins if lock_own=1 or starve_cnt==STARVE; otherwise F wins.
  - f_gnt and l_gnt are never both 1.
- mem_en = f_gnt|l_gnt.
- mem_we = l_gnt & l_we.
- mem_addr and mem_wdata come from the granted requester; mem_wdata=0 on fetch grants.
- With no grant, mem_addr and mem_wdata hold 0.
- starve_cnt (4 bits, reset 0):
  - Increments when f_gnt & l_req (saturates at STARVE).
  - Clears when l_gnt or !l_req.
- lock_own (reset 0):
  - Set on l_gnt & l_lock.
  - Cleared when l_lock=0 or l_req=0.
  - While set, starve_cnt does not increment.
- Read return:
  - Registered rd_pend (reset 0) and rd_owner (0=F, 1=L) are captured each cycle from (f_gnt | l_gnt&!l_we) and the owner.
  - f_rvalid = rd_pend & !rd_owner; l_rvalid = rd_pend & rd_owner.
  - Latency is exactly 1 cycle after gnt.
  - Only the owner's rdata carries mem_rdata; the non-owner's rdata is 0.
  - Loader writes produce no rvalid.
- Reset values: all registers 0; f_rvalid=l_rvalid=0, f_rdata=l_rdata=0.
- Reset mid-operation: a read granted in the cycle rst asserts produces no rvalid; the pending read is dropped.
- Back-to-back: a read grant every cycle yields rvalid every cycle, in grant order.
- Write-then-read to the same address from L on consecutive cycles returns the new data.

Test Plan:
- F only: f_req=1, f_addr 0..7 for 8 cycles -> f_gnt=1 each cycle, f_rvalid each following cycle, f_rdata=mem[addr], l_gnt=0 throughout.
- Contention, STARVE=4: f_req and l_req held 1, l_we=0, l_addr=0x10 -> f_gnt for 4 cycles, l_gnt on cycle 5, l_rvalid on cycle 6 with mem[0x10], then F resumes.
- Lock burst: l_lock=1, l_we=1, addresses 0x20..0x23 with data 0xA0..0xA3, f_req=1 -> the first loader grant follows the starvation rule, then 3 consecutive l_gnt with F stalled. Lock drop returns priority to F. Read-back of 0x20..0x23 returns 0xA0..0xA3.
- Write/read: L writes 0xDEADBEEF to 0x05, then reads 0x05 -> l_rvalid with 0xDEADBEEF. No rvalid on the write cycle.
- Reset mid-read: F granted at 0x03 with rst=1 that cycle -> no f_rvalid next cycle. starve_cnt=0, all outputs 0 during rst.
- Idle: f_req=l_req=0 -> mem_en=0, no rvalid, starve_cnt stays 0.
